// File: rtl/cache_pkg.sv
// Shared geometry, state encoding and address helper for the cache line / memory adapter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cache_pkg;

  localparam int s_offset = 5;                    // byte-offset bits per line
  localparam int s_line   = 8 * (2 ** s_offset);  // line width in bits
  localparam int s_word   = 32;                   // memory bus data width
  localparam int s_beats  = s_line / s_word;      // beats per line (power of two)
  localparam int s_bidx   = $clog2(s_beats);      // beat index width
  localparam int s_cnt    = s_bidx + 1;           // counter width, holds the value s_beats
  localparam int s_wbyte  = $clog2(s_word / 8);   // byte-offset bits inside one word

  localparam logic [s_cnt-1:0] s_beats_cnt = s_cnt'(s_beats);
  localparam logic [31:0]      s_off_mask  = 32'((1 << s_offset) - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RESP
  } state_t;

  // Beat address inside the line: the index only replaces the word-offset
  // field, so it wraps within the line and can never carry into the tag/index.
  function automatic logic [31:0] beat_addr(input logic [31:0]       base,
                                            input logic [s_bidx-1:0] idx);
    return base | 32'({idx, {s_wbyte{1'b0}}});
  endfunction

endpackage

// File: rtl/line_beat_buffer.sv
// One-line staging register: whole-line load/output plus word-indexed write and read.
// Latency: writes visible the cycle after the edge; reads are combinational from the register.
// Backpressure: none; the owner decides when to load or write.
// Ports: i_line_load/i_line_dat  whole-line parallel load (writeback data)
//        i_word_we/i_word_idx/i_word_dat  single-word write (returned read beats)
//        i_rd_idx -> o_rd_word  word select for writeback beats; o_line  whole line
module line_beat_buffer
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_line_load,
  input  logic [s_line-1:0] i_line_dat,
  input  logic              i_word_we,
  input  logic [s_bidx-1:0] i_word_idx,
  input  logic [s_word-1:0] i_word_dat,
  input  logic [s_bidx-1:0] i_rd_idx,
  output logic [s_word-1:0] o_rd_word,
  output logic [s_line-1:0] o_line
);

  // Word i sits at bits [s_word*i +: s_word], so the packed array matches the line layout.
  logic [s_beats-1:0][s_word-1:0] r_line;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_line <= '0;
    end else if (i_line_load) begin
      r_line <= i_line_dat;
    end else if (i_word_we) begin
      r_line[i_word_idx] <= i_word_dat;
    end
  end

  assign o_rd_word = r_line[i_rd_idx];
  assign o_line    = r_line;

endmodule

// File: rtl/cache_line_mem_adapter.sv
// Cache-side line fill/writeback responder that serialises lines into word beats on the memory bus.
// Latency: accept at T -> first beat T+1; write resp T+9, read resp T+10 with no stalls.
// Backpressure: line_ready only in IDLE; mem_gnt low holds the current beat; reads tolerate any rvalid delay.
// Ports: clk, rst (async active-low)
//        line_valid/line_ready/line_we/line_addr/line_wdata  request from the cache
//        line_resp/line_rdata  completion pulse and fill data
//        mem_req/mem_we/mem_addr/mem_wdata/mem_gnt  beat request channel
//        mem_rvalid/mem_rdata  in-order read data return
module cache_line_mem_adapter
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              line_valid,
  output logic              line_ready,
  input  logic              line_we,
  input  logic [31:0]       line_addr,
  input  logic [s_line-1:0] line_wdata,
  output logic              line_resp,
  output logic [s_line-1:0] line_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [s_word-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [s_word-1:0] mem_rdata
);

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_base;
  logic              r_we;
  logic [s_cnt-1:0]  r_req_cnt, w_req_cnt_nxt;
  logic [s_cnt-1:0]  r_rsp_cnt, w_rsp_cnt_nxt;
  logic              r_mem_req, w_mem_req_nxt;
  logic              r_mem_we, w_mem_we_nxt;
  logic [31:0]       r_mem_addr, w_mem_addr_nxt;
  logic [s_word-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [s_line-1:0] r_rdata;

  logic              w_accept;
  logic              w_gnt;
  logic              w_rvld;
  logic [s_cnt-1:0]  w_req_cnt_inc;
  logic [s_cnt-1:0]  w_rsp_cnt_inc;
  logic [31:0]       w_line_base;
  logic [s_word-1:0] w_buf_word;
  logic [s_line-1:0] w_buf_line;
  logic              w_fill_done;

  assign line_ready    = (r_state == IDLE);
  assign w_accept      = line_valid && line_ready;
  assign w_gnt         = r_mem_req && mem_gnt;
  // Responses are only meaningful while a fill is in flight; anything else
  // (including stale beats from an operation killed by reset) is dropped.
  assign w_rvld        = (r_state == READ) && mem_rvalid;
  assign w_req_cnt_inc = r_req_cnt + 1'b1;
  assign w_rsp_cnt_inc = r_rsp_cnt + 1'b1;
  assign w_line_base   = line_addr & ~s_off_mask;
  assign w_fill_done   = (r_state == RESP) && !r_we;

  line_beat_buffer u_buf (
    .clk        (clk),
    .rst        (rst),
    .i_line_load(w_accept && line_we),
    .i_line_dat (line_wdata),
    .i_word_we  (w_rvld),
    .i_word_idx (r_rsp_cnt[s_bidx-1:0]),
    .i_word_dat (mem_rdata),
    .i_rd_idx   (w_req_cnt_inc[s_bidx-1:0]),
    .o_rd_word  (w_buf_word),
    .o_line     (w_buf_line)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus next values of the registered memory-bus outputs.
  always_comb begin
    w_state_nxt     = r_state;
    w_req_cnt_nxt   = r_req_cnt;
    w_rsp_cnt_nxt   = r_rsp_cnt;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    case (r_state)
      IDLE: begin
        if (line_valid) begin
          w_state_nxt     = line_we ? WRITE : READ;
          w_req_cnt_nxt   = '0;
          w_rsp_cnt_nxt   = '0;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = line_we;
          w_mem_addr_nxt  = w_line_base;
          // The buffer is loaded on this same edge, so beat 0 comes straight from the input.
          w_mem_wdata_nxt = line_wdata[s_word-1:0];
        end
      end
      WRITE: begin
        if (w_gnt) begin
          w_req_cnt_nxt = w_req_cnt_inc;
          if (w_req_cnt_inc == s_beats_cnt) begin
            w_mem_req_nxt = 1'b0;
            w_state_nxt   = RESP;
          end else begin
            w_mem_addr_nxt  = beat_addr(r_base, w_req_cnt_inc[s_bidx-1:0]);
            w_mem_wdata_nxt = w_buf_word;
          end
        end
      end
      READ: begin
        if (w_gnt) begin
          w_req_cnt_nxt = w_req_cnt_inc;
          if (w_req_cnt_inc == s_beats_cnt) begin
            w_mem_req_nxt = 1'b0;
          end else begin
            w_mem_addr_nxt = beat_addr(r_base, w_req_cnt_inc[s_bidx-1:0]);
          end
        end
        // Request and response counters advance independently: a grant for a
        // later beat and the data of an earlier one may land in the same cycle.
        if (w_rvld) begin
          w_rsp_cnt_nxt = w_rsp_cnt_inc;
          if (w_rsp_cnt_inc == s_beats_cnt) begin
            w_state_nxt = RESP;
          end
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base      <= '0;
      r_we        <= 1'b0;
      r_req_cnt   <= '0;
      r_rsp_cnt   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      if (w_accept) begin
        r_base <= w_line_base;
        r_we   <= line_we;
      end
      r_req_cnt   <= w_req_cnt_nxt;
      r_rsp_cnt   <= w_rsp_cnt_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      if (w_fill_done) begin
        r_rdata <= w_buf_line;
      end
    end
  end

  assign line_resp = (r_state == RESP);
  // The last read word lands in the buffer on the edge entering RESP, so the
  // completion cycle shows the buffer directly; r_rdata holds it afterwards.
  assign line_rdata = w_fill_done ? w_buf_line : r_rdata;

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_cache_line_mem_adapter.sv
module tb_cache_line_mem_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic         line_valid;
  logic         line_ready;
  logic         line_we;
  logic [31:0]  line_addr;
  logic [255:0] line_wdata;
  logic         line_resp;
  logic [255:0] line_rdata;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_gnt;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;

  cache_line_mem_adapter dut (
    .clk       (clk),
    .rst       (rst),
    .line_valid(line_valid),
    .line_ready(line_ready),
    .line_we   (line_we),
    .line_addr (line_addr),
    .line_wdata(line_wdata),
    .line_resp (line_resp),
    .line_rdata(line_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input bit ok, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { logic [31:0] a; logic we; logic [31:0] d; } beat_t;
  typedef struct { logic [31:0] d; int due; } rsp_t;

  beat_t        exp_q[$];     // beats the bus must carry, in order
  rsp_t         rq[$];        // memory model: read data awaiting return
  int           pending = 0;  // line_resp pulses still owed
  logic [255:0] exp_rdata = '0;
  logic [31:0]  rd_seed = '0; // memory returns rd_seed + word-in-line for reads

  function automatic logic [255:0] make_line(input logic [31:0] s);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = s + 32'(i);
    return l;
  endfunction

  // Called when the cache request is accepted: a line is 8 ascending words
  // starting at the 32-byte-aligned base; a fill yields rd_seed+i in word i.
  task automatic model_issue();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{a: (line_addr & ~32'h1F) + 32'(4 * i), we: line_we,
                        d: line_we ? line_wdata[32*i +: 32] : 32'h0});
    end
    if (!line_we) exp_rdata = make_line(rd_seed);
    pending++;
  endtask

  task automatic model_reset();
    exp_q.delete();
    pending   = 0;
    exp_rdata = '0;
  endtask

  // ---------------- compare process ----------------
  beat_t       e;
  logic        prev_stall = 1'b0;
  logic [31:0] pa, pd;
  logic        pw;

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (mem_req && mem_gnt) begin
        if (exp_q.size() == 0) begin
          chk("beat_unexpected", 1'b0, mem_addr, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_addr", mem_addr === e.a, mem_addr, e.a);
          chk("beat_we", mem_we === e.we, mem_we, e.we);
          if (e.we) chk("beat_wdata", mem_wdata === e.d, mem_wdata, e.d);
        end
      end
      if (prev_stall) begin
        chk("stall_hold", mem_req && mem_addr === pa && mem_we === pw && mem_wdata === pd,
            {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, pw, pa, pd});
      end
      prev_stall = mem_req && !mem_gnt;
      pa = mem_addr;
      pw = mem_we;
      pd = mem_wdata;
      if (line_resp) begin
        chk("resp_expected", pending > 0, pending, 1);
        if (pending > 0) pending--;
        chk("resp_rdata", line_rdata === exp_rdata, line_rdata, exp_rdata);
      end
    end
  end

  // ---------------- stimulus / memory responder ----------------
  int          cyc = 0;
  bit          gnt_toggle = 1'b0;
  int          rv_delay = 1;
  int          gcount = 0;
  logic [31:0] first_ga, last_ga;
  int          acc_cnt = 0, acc_cyc = 0, resp_cnt = 0, resp_cyc = 0;

  // Called shortly after a rising edge: records what happens at the coming
  // edge, then drives the memory side for the next cycle.
  task automatic tick();
    logic        g, grd;
    logic [31:0] ga;
    g   = mem_req && mem_gnt;
    grd = g && !mem_we;
    ga  = mem_addr;
    if (g) begin
      gcount++;
      if (gcount == 1) first_ga = ga;
      last_ga = ga;
    end
    if (line_valid && line_ready && rst) begin
      acc_cnt++;
      acc_cyc = cyc;
      model_issue();
    end
    if (line_resp) begin
      resp_cnt++;
      resp_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (grd) rq.push_back('{d: rd_seed + 32'((ga >> 2) & 32'h7), due: cyc - 1 + rv_delay});
    mem_gnt = !gnt_toggle || (cyc % 2 == 0);
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rq[0].d;
      void'(rq.pop_front());
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic wait_accept(input int a0);
    int n = 0;
    while (acc_cnt == a0 && n < 60) begin tick(); n++; end
    if (acc_cnt == a0) chk("accept_timeout", 1'b0, n, 60);
  endtask

  // One complete operation; returns accept-to-resp latency, cycles with
  // line_ready low up to the resp cycle, and line_rdata seen at resp.
  task automatic do_op(input logic we, input logic [31:0] addr, input logic [31:0] seed,
                       output int lat, output int nrl, output logic [255:0] rd);
    int a0, n;
    bit seen;
    line_we    = we;
    line_addr  = addr;
    line_wdata = make_line(seed);
    rd_seed    = seed;
    gcount     = 0;
    line_valid = 1'b1;
    a0 = acc_cnt;
    wait_accept(a0);
    line_valid = 1'b0;
    nrl = 0; n = 0; seen = 1'b0; lat = -1; rd = '0;
    while (n < 200) begin
      if (!line_ready) nrl++;
      if (line_resp) begin seen = 1'b1; break; end
      tick(); n++;
    end
    if (!seen) begin
      chk("resp_timeout", 1'b0, n, 200);
    end else begin
      lat = cyc - acc_cyc;
      rd  = line_rdata;
      tick();
    end
  endtask

  int           lat, nrl, r0, n, a0;
  logic [255:0] rd;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; line_valid = 1'b0; line_we = 1'b0; line_addr = '0; line_wdata = '0;
    mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    #2;
    chk("reset_mem_req_in_reset", mem_req === 1'b0, mem_req, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("reset_ready", line_ready === 1'b1, line_ready, 1);
    chk("reset_resp", line_resp === 1'b0, line_resp, 0);
    chk("reset_mem_regs", {mem_req, mem_we, mem_addr, mem_wdata} === 66'h0,
        {mem_req, mem_we, mem_addr, mem_wdata}, 0);
    chk("reset_rdata", line_rdata === '0, line_rdata, 0);

    // Writeback 0x1234, words 0xA0+i, grant always high
    do_op(1'b1, 32'h0000_1234, 32'hA0, lat, nrl, rd);
    chk("wb_latency", lat == 9, lat, 9);
    chk("wb_ready_low", nrl == 9, nrl, 9);
    chk("wb_ready_after", line_ready === 1'b1, line_ready, 1);
    chk("wb_first_addr", first_ga == 32'h1220, first_ga, 32'h1220);
    chk("wb_last_addr", last_ga == 32'h123C, last_ga, 32'h123C);

    // Fill 0x40, rvalid one cycle after each grant
    do_op(1'b0, 32'h0000_0040, 32'h1000, lat, nrl, rd);
    chk("fill_latency", lat == 10, lat, 10);
    chk("fill_first_addr", first_ga == 32'h40, first_ga, 32'h40);
    chk("fill_last_addr", last_ga == 32'h5C, last_ga, 32'h5C);
    chk("fill_word0", rd[31:0] == 32'h1000, rd[31:0], 32'h1000);
    chk("fill_word7", rd[255:224] == 32'h1007, rd[255:224], 32'h1007);

    // Fill with toggling grant and 3-cycle read return
    gnt_toggle = 1'b1; rv_delay = 3;
    r0 = resp_cnt;
    do_op(1'b0, 32'h0000_0300, 32'h2000, lat, nrl, rd);
    chk("stall_grants", gcount == 8, gcount, 8);
    chk("stall_word3", rd[127:96] == 32'h2003, rd[127:96], 32'h2003);
    repeat (4) tick();
    chk("stall_single_resp", resp_cnt == r0 + 1, resp_cnt, r0 + 1);

    // Back-to-back: writeback 0x100 then fill 0x200 with valid held
    gnt_toggle = 1'b0; rv_delay = 1;
    line_we = 1'b1; line_addr = 32'h0000_0100; line_wdata = make_line(32'hB0);
    r0 = resp_cnt; a0 = acc_cnt; line_valid = 1'b1;
    wait_accept(a0);
    line_we = 1'b0; line_addr = 32'h0000_0200; rd_seed = 32'h6000;
    wait_accept(a0 + 1);
    line_valid = 1'b0;
    chk("b2b_resp_before", resp_cnt == r0 + 1, resp_cnt, r0 + 1);
    chk("b2b_accept_cycle", acc_cyc == resp_cyc + 1, acc_cyc, resp_cyc + 1);
    n = 0;
    while (!line_resp && n < 50) begin tick(); n++; end
    chk("b2b_fill_word1", line_rdata[63:32] === 32'h6001, line_rdata[63:32], 32'h6001);
    tick();

    // Reset after the third read grant, then stale returns
    rv_delay = 3;
    line_we = 1'b0; line_addr = 32'h0000_0500; rd_seed = 32'h3000;
    gcount = 0; a0 = acc_cnt; line_valid = 1'b1;
    wait_accept(a0);
    line_valid = 1'b0;
    n = 0;
    while (gcount < 3 && n < 30) begin tick(); n++; end
    chk("rst_three_grants", gcount == 3, gcount, 3);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_req_drop", mem_req === 1'b0, mem_req, 0);
    chk("rst_rdata_clear", line_rdata === '0, line_rdata, 0);
    r0 = resp_cnt;
    tick(); tick();
    rst = 1'b1;
    n = 0;
    while (rq.size() > 0 && n < 20) begin tick(); n++; end
    tick(); tick();
    chk("rst_no_resp", resp_cnt == r0, resp_cnt, r0);
    chk("rst_rdata_after_stale", line_rdata === '0, line_rdata, 0);
    chk("rst_ready", line_ready === 1'b1, line_ready, 1);
    rv_delay = 1;
    do_op(1'b0, 32'h0000_0600, 32'h4000, lat, nrl, rd);
    chk("post_rst_latency", lat == 10, lat, 10);
    chk("post_rst_word0", rd[31:0] == 32'h4000, rd[31:0], 32'h4000);
    chk("post_rst_word7", rd[255:224] == 32'h4007, rd[255:224], 32'h4007);

    // Unaligned address, writeback with grant stalls
    gnt_toggle = 1'b1;
    do_op(1'b1, 32'h0000_009F, 32'hC0, lat, nrl, rd);
    chk("unal_first_addr", first_ga == 32'h80, first_ga, 32'h80);
    chk("unal_last_addr", last_ga == 32'h9C, last_ga, 32'h9C);
    chk("unal_grants", gcount == 8, gcount, 8);
    chk("unal_rdata_kept", rd[31:0] == 32'h4000, rd[31:0], 32'h4000);

    repeat (3) tick();
    chk("model_drained", exp_q.size() == 0 && pending == 0, exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_line_mem_adapter.md
Name: cache_line_mem_adapter

Overview:
Memory-side responder for the 2-way cache datapath's line traffic.
- Accepts whole-line fill (read) and writeback (write) requests from the cache controller.
- Serialises each line into word-wide beats on the main-memory bus; on reads, reassembles the returned words into a line.
- Sits between the cache controller/datapath and main memory.

Parameters:
s_offset, 5, byte-offset bits per line; line = 2**s_offset bytes
s_line, 8*2**s_offset (256), line width in bits
s_word, 32, memory bus data width in bits
s_beats, s_line/s_word (8), beats per line; must be a power of two

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
line_valid  in  1  cache presents a line request
line_ready  out  1  adapter idle and able to accept; high only in IDLE
line_we  in  1  1 = writeback, 0 = fill; sampled on accept
line_addr  in  32  line address; low s_offset bits ignored (forced 0)
line_wdata  in  s_line  writeback data; sampled on accept
line_resp  out  1  one-cycle completion pulse for either operation
line_rdata  out  s_line  fill data; valid with line_resp, held until next fill completes
mem_req  out  1  memory beat request valid
mem_we  out  1  beat is a write
mem_addr  out  32  beat byte address
mem_wdata  out  s_word  write beat data
mem_gnt  in  1  memory accepts current beat this cycle (mem_req & mem_gnt)
mem_rvalid  in  1  read data valid; in request order, zero or more cycles after its grant
mem_rdata  in  s_word  read beat data

Behaviour:
- Reset (rst low, asynchronous) clears:
  - state to IDLE
  - line_resp = 0, line_rdata = 0
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0
  - all counters
  - line_ready is 1 once reset is released.
- Accept occurs when line_valid & line_ready. On accept, register:
  - base = {line_addr[31:s_offset], 0}
  - line_we
  - line_wdata (write only)
- States:
  - IDLE: on accept, go to WRITE or READ.
  - WRITE: for each beat, mem_req=1, mem_we=1, mem_addr=base+4*beat, mem_wdata=line word[beat]. Advance the beat on grant. On the s_beats-th grant, go to RESP. Writes are posted; no response is awaited.
  - READ: mem_req=1 and mem_we=0 while req_cnt < s_beats; mem_addr=base+4*req_cnt; req_cnt increments on grant. Each mem_rvalid stores mem_rdata into buffer word rsp_cnt, then rsp_cnt increments. When the s_beats-th rvalid is stored, go to RESP.
  - RESP: line_resp=1 for exactly one cycle. If the operation was a read, line_rdata = assembled buffer. Then go to IDLE.
- Word order:
  - Word i occupies line bits [s_word*i+s_word-1 : s_word*i].
  - Beats are issued in ascending address order, word 0 first.
- mem_* outputs are driven from registers only; there is no combinational path from mem_gnt or mem_rvalid to any output.
- Latency, accept at cycle T:
  - First mem_req at T+1.
  - Write with mem_gnt held high: beats at T+1..T+8, line_resp at T+9.
  - Read with gnt held high and rvalid one cycle after gnt: line_resp at T+10.
- mem_rvalid in the same cycle as a grant of a later beat is legal. Both counters update in that cycle.
- mem_gnt stalls hold mem_addr, mem_wdata and mem_we stable until granted.
- mem_rvalid outside READ is ignored. This includes stale responses arriving after a reset mid-read.
- line_valid outside IDLE is ignored; the cache holds its request until line_ready.
- Counters are $clog2(s_beats)+1 bits wide. The beat address offset wraps within the line and never carries into the tag/index bits.
- Reset mid-operation aborts immediately:
  - mem_req drops asynchronously.
  - No line_resp is issued.
  - line_rdata returns to 0.

Decomposition:
- cache_pkg holds:
  - s_offset, s_line, s_word, s_beats
  - beat counter width
  - state enum {IDLE, WRITE, READ, RESP}
- One sub-module, line_beat_buffer: an s_line register with word-indexed write (load from mem_rdata) and word-indexed read mux (writeback beat select), plus a whole-line parallel load and output.
- FSM and counters stay in the top level.

Test Plan:
- Writeback, line_addr=0x0000_1234, line_wdata word i = 0xA0+i, mem_gnt=1 -> beats at 0x1220..0x123C with wdata 0xA0..0xA7, mem_we=1, line_resp at T+9, line_ready low T+1..T+9.
- Fill, line_addr=0x0000_0040, gnt=1, rvalid one cycle after each gnt with rdata 0x1000+i -> addresses 0x40..0x5C, line_rdata word i = 0x1000+i at line_resp (T+10).
- Fill with gnt toggling 1,0,1,0 and rvalid delayed 3 cycles -> mem_addr stable across stalls, exactly 8 grants, word order correct, single line_resp.
- Back-to-back: writeback of 0x0000_0100, then fill of 0x0000_0200 with line_valid held -> second accept in the IDLE cycle after line_resp, no beat overlap, line_rdata unchanged by the writeback.
- Reset asserted after the 3rd read grant, then stale rvalid pulses -> mem_req 0 immediately, no line_resp, line_rdata = 0, stale data ignored, next fill completes correctly.
- line_addr with low bits 0x1F set (0x0000_009F) -> first beat at 0x80, last at 0x9C, no carry into bit 8.
